sqrt_share_arb: RTL and testbench

//  Round-robin arbiter sharing one fixed-latency, non-stallable fixed-point sqrt pipeline among
//  N requesters (path-generation lanes needing sqrt(dt) and sqrt(variance) terms).

---
 rtl/fpga_cfg_pkg.sv | 11 +
 rtl/sqrt_share_arb_tag_fifo.sv | 63 ++++++
 rtl/sqrt_share_arb.sv | 143 ++++++++++++++
 tb/tb_sqrt_share_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the path-generation datapath.
// Also holds the requester count and tag type for the shared sqrt arbiter.
package fpga_cfg_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int FP_QINT       = 16;
  localparam int SQRT_ARB_NREQ = 4;

  typedef logic [$clog2(SQRT_ARB_NREQ)-1:0] sqrt_tag_t;

endpackage

// File: rtl/sqrt_share_arb_tag_fifo.sv
// Synchronous FIFO that remembers which requester owns each in-flight sqrt op.
// Push/pop are ignored when full/empty respectively; occupancy count is registered.
module sqrt_share_arb_tag_fifo #(
  parameter int DW    = 2,
  parameter int DEPTH = 8
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == {CW{1'b0}});
  assign o_count   = r_cnt;
  assign o_data    = r_mem[r_rd];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Tag storage; contents beyond the count are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= {AW{1'b0}};
      r_rd  <= {AW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr <= (r_wr == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= (r_rd == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_share_arb.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable sqrt pipeline among N_REQ lanes.
// A tag FIFO records the owner of each issued op so results route back in issue order.
module sqrt_share_arb
  import fpga_cfg_pkg::*;
#(
  parameter int N_REQ        = SQRT_ARB_NREQ,
  parameter int WIDTH        = FP_WIDTH,
  parameter int QINT         = FP_QINT,
  parameter int MAX_INFLIGHT = 8
)(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*WIDTH-1:0]              req_data,
  output logic                                sq_valid_in,
  output logic [WIDTH-1:0]                    sq_a,
  input  logic                                sq_valid_out,
  input  logic [WIDTH-1:0]                    sq_result,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [WIDTH-1:0]                    rsp_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                err_neg,
  output logic                                err_orphan,
  input  logic                                clr_err
);

  localparam int TAG_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("N_REQ must be in 2..16");
  end
  if (QINT < 0 || QINT > WIDTH) begin : g_bad_qint
    $error("QINT must lie within WIDTH");
  end

  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_sq_valid;
  logic [WIDTH-1:0] r_sq_a;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_err_neg;
  logic             r_err_orphan;

  logic             w_found;
  logic [TAG_W-1:0] w_win;
  logic [TAG_W-1:0] w_cand;
  logic [WIDTH-1:0] w_op;
  logic             w_neg;
  logic             w_push;
  logic             w_pop;
  logic             w_orphan;
  logic             w_full;
  logic             w_empty;
  logic [TAG_W-1:0] w_tag_head;

  // Rotating priority search starting one past the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = {TAG_W{1'b0}};
    w_cand  = {TAG_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = TAG_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grant only while the registered full flag is clear, so a same-cycle pop cannot unblock.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if (w_found && !w_full) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  assign w_push   = w_found & ~w_full;
  assign w_op     = req_data[w_win*WIDTH +: WIDTH];
  assign w_neg    = w_op[WIDTH-1];
  assign w_pop    = sq_valid_out & ~w_empty;
  assign w_orphan = sq_valid_out & w_empty;

  sqrt_share_arb_tag_fifo #(
    .DW    (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_data  (w_tag_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (inflight)
  );

  // Issue, response and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= TAG_W'(N_REQ - 1);
      r_sq_valid  <= 1'b0;
      r_sq_a      <= {WIDTH{1'b0}};
      r_rsp_valid <= {N_REQ{1'b0}};
      r_rsp_data  <= {WIDTH{1'b0}};
    end else begin
      r_rr_ptr    <= w_push ? w_win : r_rr_ptr;
      r_sq_valid  <= w_push;
      // Negative operands still occupy a slot so the requester gets a (zero) answer.
      r_sq_a      <= w_push ? (w_neg ? {WIDTH{1'b0}} : w_op) : r_sq_a;
      r_rsp_valid <= w_pop ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_tag_head) : {N_REQ{1'b0}};
      r_rsp_data  <= w_pop ? sq_result : r_rsp_data;
    end
  end

  // Sticky error flags; a clear wins over a simultaneous new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_neg    <= 1'b0;
      r_err_orphan <= 1'b0;
    end else if (clr_err) begin
      r_err_neg    <= 1'b0;
      r_err_orphan <= 1'b0;
    end else begin
      r_err_neg    <= r_err_neg | (w_push & w_neg);
      r_err_orphan <= r_err_orphan | w_orphan;
    end
  end

  assign sq_valid_in = r_sq_valid;
  assign sq_a        = r_sq_a;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign err_neg     = r_err_neg;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Scoreboard bench for sqrt_share_arb using identity sqrt stubs of latency 4.
// Main instance has 8 tag slots; a second instance with 2 slots exercises the full condition.
module tb_sqrt_share_arb;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int L   = 4;
  localparam int LAT = L + 2;

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_data = '0;
  logic          sq_valid_in;
  logic [W-1:0]  sq_a;
  logic          sq_valid_out;
  logic [W-1:0]  sq_result;
  logic [N-1:0]  rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [3:0]    inflight;
  logic          err_neg;
  logic          err_orphan;
  logic          clr_err = 1'b0;
  logic          inj_orphan = 1'b0;

  logic [N-1:0]  req_valid2 = '0;
  logic [N-1:0]  req_ready2;
  logic [N*W-1:0] req_data2;
  logic          sq_valid_in2;
  logic [W-1:0]  sq_a2;
  logic          sq_valid_out2;
  logic [W-1:0]  sq_result2;
  logic [N-1:0]  rsp_valid2;
  logic [W-1:0]  rsp_data2;
  logic [1:0]    inflight2;
  logic          err_neg2;
  logic          err_orphan2;
  logic          clr_err2 = 1'b0;

  sqrt_share_arb #(.N_REQ(N), .WIDTH(W), .QINT(16), .MAX_INFLIGHT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .sq_valid_in(sq_valid_in), .sq_a(sq_a), .sq_valid_out(sq_valid_out), .sq_result(sq_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .err_neg(err_neg),
    .err_orphan(err_orphan), .clr_err(clr_err)
  );

  sqrt_share_arb #(.N_REQ(N), .WIDTH(W), .QINT(16), .MAX_INFLIGHT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_data(req_data2),
    .sq_valid_in(sq_valid_in2), .sq_a(sq_a2), .sq_valid_out(sq_valid_out2), .sq_result(sq_result2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .inflight(inflight2), .err_neg(err_neg2),
    .err_orphan(err_orphan2), .clr_err(clr_err2)
  );

  // Identity sqrt stubs: result = operand delayed by L cycles.
  logic [L-1:0] sv_pipe, sv2_pipe;
  logic [W-1:0] sd_pipe [L];
  logic [W-1:0] sd2_pipe [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_pipe  <= '0;
      sv2_pipe <= '0;
      for (int i = 0; i < L; i++) begin
        sd_pipe[i]  <= '0;
        sd2_pipe[i] <= '0;
      end
    end else begin
      sv_pipe     <= {sv_pipe[L-2:0], sq_valid_in};
      sv2_pipe    <= {sv2_pipe[L-2:0], sq_valid_in2};
      sd_pipe[0]  <= sq_a;
      sd2_pipe[0] <= sq_a2;
      for (int i = 1; i < L; i++) begin
        sd_pipe[i]  <= sd_pipe[i-1];
        sd2_pipe[i] <= sd2_pipe[i-1];
      end
    end
  end
  assign sq_valid_out  = sv_pipe[L-1] | inj_orphan;
  assign sq_result     = sd_pipe[L-1];
  assign sq_valid_out2 = sv2_pipe[L-1];
  assign sq_result2    = sd2_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester model and scoreboard.
  logic [31:0] rq_mem [N][16];
  int          rq_head [N];
  int          rq_tail [N];
  int          m_rr = N - 1;
  exp_t        sb_q [$];

  task automatic enqueue(input int r, input logic [31:0] d);
    rq_mem[r][rq_tail[r] % 16] = d;
    rq_tail[r]++;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rq_head[i] != rq_tail[i]);
      req_data[i*W +: W] = (rq_head[i] != rq_tail[i]) ? rq_mem[i][rq_head[i] % 16] : 32'h0;
    end
  endtask

  task automatic step();
    int           w;
    logic [N-1:0] er;
    logic [31:0]  d;
    exp_t         e;
    @(negedge clk);
    apply_inputs();
    #1;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (w < 0 && rq_head[idx] != rq_tail[idx]) w = idx;
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (w >= 0) begin
      d      = rq_mem[w][rq_head[w] % 16];
      e.tag  = 2'(w);
      e.data = d[31] ? 32'h0 : d;
      e.cyc  = 32'(cyc);
      sb_q.push_back(e);
      rq_head[w]++;
      m_rr = w;
    end
    #1;
    apply_inputs();
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor for the main instance: every response must match the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_valid_route", 64'(rsp_valid), 64'(4'b0001 << mon_e.tag));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        check("rsp_latency", 64'(32'(cyc) - mon_e.cyc), 64'(LAT));
      end
    end
  end

  // Small-FIFO instance: occupancy bound, stall while full, routing and conservation.
  logic         en2 = 1'b0;
  logic         saw_full = 1'b0;
  int           acc2 = 0;
  int           rsp2 = 0;
  int           exp2_tag = 0;
  for (genvar g = 0; g < N; g++) begin : g_d2
    assign req_data2[g*W +: W] = {16'(g + 1), 16'h0};
  end

  always @(posedge clk) begin
    if (en2 && (req_valid2 & req_ready2) != '0) acc2 <= acc2 + 1;
  end

  always @(negedge clk) begin
    if (rst_n && en2) begin
      check("inflight2_bound", 64'(inflight2 > 2'd2), 64'd0);
      if (inflight2 == 2'd2) begin
        saw_full = 1'b1;
        check("ready2_while_full", 64'(req_ready2), 64'd0);
      end
      if (rsp_valid2 != '0) begin
        check("rsp2_route", 64'(rsp_valid2), 64'(4'b0001 << exp2_tag));
        check("rsp2_data", 64'(rsp_data2), 64'({16'(exp2_tag + 1), 16'h0}));
        exp2_tag = (exp2_tag + 1) % N;
        rsp2++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_sq_valid_in", 64'(sq_valid_in), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_inflight", 64'(inflight), 64'd0);
    check("reset_err", 64'({err_neg, err_orphan}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from lane 1.
    enqueue(1, 32'h0004_0000);
    step();
    @(negedge clk);
    check("t1_sq_valid_in", 64'(sq_valid_in), 64'd1);
    check("t1_sq_a", 64'(sq_a), 64'h0004_0000);
    check("t1_inflight", 64'(inflight), 64'd1);
    drain();
    check("t1_inflight_drained", 64'(inflight), 64'd0);

    // All lanes busy: rotating grants with back-to-back issue.
    for (int r = 0; r < N; r++)
      for (int s = 0; s < 3; s++)
        enqueue(r, {8'(r + 1), 8'h00, 16'(s * 16'h0111 + 16'h0010)});
    repeat (12) step();
    drain();

    // Constant requests on the 2-slot instance.
    @(negedge clk);
    en2 = 1'b1;
    req_valid2 = 4'hF;
    repeat (40) @(negedge clk);
    req_valid2 = 4'h0;
    repeat (12) @(negedge clk);
    check("fifo2_conservation", 64'(rsp2), 64'(acc2));
    check("fifo2_saw_full", 64'(saw_full), 64'd1);
    check("fifo2_inflight_drained", 64'(inflight2), 64'd0);
    en2 = 1'b0;

    // Negative operand: zero issued, flag set, still answered.
    enqueue(2, 32'h8000_0001);
    step();
    @(negedge clk);
    check("t4_sq_a_zero", 64'(sq_a), 64'd0);
    check("t4_sq_valid_in", 64'(sq_valid_in), 64'd1);
    check("t4_err_neg", 64'(err_neg), 64'd1);
    drain();
    check("t4_err_neg_sticky", 64'(err_neg), 64'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("t4_err_neg_cleared", 64'(err_neg), 64'd0);

    // Clear and a new negative in the same cycle: clear wins.
    enqueue(3, 32'hFFFF_0000);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_clr_priority", 64'(err_neg), 64'd0);
    drain();

    // Orphan result with an empty tag FIFO.
    inj_orphan = 1'b1;
    @(posedge clk);
    #1;
    inj_orphan = 1'b0;
    check("t5_err_orphan", 64'(err_orphan), 64'd1);
    check("t5_no_rsp", 64'(rsp_valid), 64'd0);
    check("t5_inflight", 64'(inflight), 64'd0);
    @(posedge clk);
    #1;
    check("t5_no_rsp_later", 64'(rsp_valid), 64'd0);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("t5_err_orphan_cleared", 64'(err_orphan), 64'd0);

    // Reset with three ops in flight.
    enqueue(0, 32'h0000_1000);
    enqueue(1, 32'h0000_2000);
    enqueue(2, 32'h0000_3000);
    repeat (3) step();
    @(negedge clk);
    check("t6_inflight_before", 64'(inflight), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t6_sq_valid_in", 64'(sq_valid_in), 64'd0);
    check("t6_sq_a", 64'(sq_a), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rsp_data", 64'(rsp_data), 64'd0);
    check("t6_inflight", 64'(inflight), 64'd0);
    sb_q.delete();
    for (int i = 0; i < N; i++) rq_head[i] = rq_tail[i];
    m_rr = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) enqueue(r, {16'h0007, 16'(r)});
    step();
    check("t6_first_grant_seen", 64'(m_rr), 64'd0);
    repeat (3) step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
